uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 133 +++++++++++++
 tb/tb_uart_tx_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding a single UART transmitter byte stream.
// Optional tag header per packet; idle-requester timeout aborts a stalled packet.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_EN  = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_valid,
  output logic [7:0]             uart_data,
  input  logic                   uart_ready,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   abort
);

  localparam int unsigned       TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]     TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_q, last_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 abort_q, abort_d;

  logic [NUM_REQ-1:0]   onehot;
  logic [NUM_REQ-1:0]   scan;
  logic                 gv, gl;
  logic [7:0]           gd;
  logic [2:0]           start;
  logic                 found;
  int unsigned          pick;
  int unsigned          arb_idx;

  always_comb begin
    onehot = NUM_REQ'(1) << grant_q;
    gv     = |(req_valid & onehot);
    gl     = |(req_last & onehot);
    gd     = 8'(req_data >> {grant_q, 3'b000});
  end

  // Rotate requests so bit 0 is last_grant+1, then take the lowest set bit.
  always_comb begin
    start   = (last_q == 3'(NUM_REQ - 1)) ? 3'd0 : last_q + 3'd1;
    scan    = NUM_REQ'({req_valid, req_valid} >> start);
    found   = 1'b0;
    pick    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && scan[0]) begin
        found = 1'b1;
        pick  = k;
      end
      scan = scan >> 1;
    end
    arb_idx = 32'(start) + pick;
    if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    abort_d    = 1'b0;
    uart_valid = 1'b0;
    uart_data  = '0;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (found) begin
          grant_d = 3'(arb_idx);
          state_d = (TAG_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        uart_valid = 1'b1;
        uart_data  = 8'hA0 | {5'b00000, grant_q};
        tmo_d      = '0;
        if (uart_ready) state_d = DATA;
      end
      DATA: begin
        uart_valid = gv;
        uart_data  = gd;
        req_ready  = uart_ready ? onehot : '0;
        if (gv && uart_ready) begin
          tmo_d = '0;
          if (gl) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end else if (!gv) begin
          // Abort fires on the edge the counter lands on TMO_MAX, so it never wraps.
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_MAX) begin
            abort_d = 1'b1;
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: tagged instance (TIMEOUT=16) and untagged instance.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        uart_ready;

  logic [3:0]  req_ready, n_req_ready;
  logic        uart_valid, n_uart_valid;
  logic [7:0]  uart_data, n_uart_data;
  logic        busy, n_busy, abort, n_abort;
  logic [2:0]  grant_id, n_grant_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(4), .TAG_EN(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_valid(uart_valid),
    .uart_data(uart_data), .uart_ready(uart_ready), .busy(busy),
    .grant_id(grant_id), .abort(abort)
  );

  uart_tx_arb #(.NUM_REQ(4), .TAG_EN(0), .TIMEOUT(1024)) dut_n (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(n_req_ready), .uart_valid(n_uart_valid),
    .uart_data(n_uart_data), .uart_ready(uart_ready), .busy(n_busy),
    .grant_id(n_grant_id), .abort(n_abort)
  );

  task automatic drv;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_ready = 1'b0;
    drv; drv;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    smp;
    tests++; if (uart_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", uart_valid); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (abort !== 1'b0) begin fails++; $display("FAIL rst_abort: got %b want 0", abort); end
    tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
  endtask

  task automatic test_single_packet;
    do_reset;
    req_valid = 4'b0001; req_data[7:0] = 8'h55; req_last = 4'b0000; uart_ready = 1'b1;
    smp;
    tests++; if (uart_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL a_idle: got valid=%b busy=%b want 0 0", uart_valid, busy); end
    drv; smp;
    tests++; if (uart_valid !== 1'b1 || uart_data !== 8'hA0) begin fails++; $display("FAIL a_hdr: got valid=%b data=%h want 1 a0", uart_valid, uart_data); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL a_hdr_ready: got %b want 0000", req_ready); end
    drv; smp;
    tests++; if (uart_data !== 8'h55 || req_ready !== 4'b0001) begin fails++; $display("FAIL a_b0: got data=%h ready=%b want 55 0001", uart_data, req_ready); end
    drv;
    req_data[7:0] = 8'h66; req_last = 4'b0001;
    smp;
    tests++; if (uart_valid !== 1'b1 || uart_data !== 8'h66) begin fails++; $display("FAIL a_b1: got valid=%b data=%h want 1 66", uart_valid, uart_data); end
    drv;
    req_valid = '0; req_last = '0;
    smp;
    tests++; if (busy !== 1'b0 || uart_valid !== 1'b0) begin fails++; $display("FAIL a_done: got busy=%b valid=%b want 0 0", busy, uart_valid); end
  endtask

  task automatic test_round_robin;
    logic [7:0] hdr, dat;
    do_reset;
    req_valid = 4'b1111; req_last = 4'b1111; uart_ready = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    drv;
    for (int p = 0; p < 5; p++) begin
      hdr = 8'hA0 + 8'(p % 4);
      dat = 8'h10 + 8'(p % 4);
      smp;
      tests++; if (uart_data !== hdr || uart_valid !== 1'b1) begin fails++; $display("FAIL b_hdr%0d: got data=%h valid=%b want %h 1", p, uart_data, uart_valid, hdr); end
      drv; smp;
      tests++; if (uart_data !== dat || req_ready !== (4'b0001 << (p % 4))) begin fails++; $display("FAIL b_dat%0d: got data=%h ready=%b want %h %b", p, uart_data, req_ready, dat, 4'b0001 << (p % 4)); end
      drv; smp;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b_idle%0d: got busy=%b want 0", p, busy); end
      drv;
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    req_valid = 4'b0100; req_data[23:16] = 8'h77; req_last = 4'b0100; uart_ready = 1'b1;
    drv; smp;
    tests++; if (uart_data !== 8'hA2 || grant_id !== 3'd2) begin fails++; $display("FAIL c_hdr: got data=%h grant=%0d want a2 2", uart_data, grant_id); end
    drv;
    uart_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      smp;
      tests++;
      if (uart_valid !== 1'b1 || uart_data !== 8'h77 || abort !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL c_stall%0d: got valid=%b data=%h abort=%b busy=%b ready=%b want 1 77 0 1 0000", i, uart_valid, uart_data, abort, busy, req_ready);
      end
      drv;
    end
    uart_ready = 1'b1;
    smp;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL c_release: got ready=%b want 0100", req_ready); end
    drv;
    req_valid = '0; req_last = '0;
    smp;
    tests++; if (busy !== 1'b0 || abort !== 1'b0) begin fails++; $display("FAIL c_done: got busy=%b abort=%b want 0 0", busy, abort); end
  endtask

  task automatic test_timeout;
    do_reset;
    req_valid = 4'b0010; req_data[15:8] = 8'h31; req_last = 4'b0000; uart_ready = 1'b1;
    drv; drv; smp;
    tests++; if (uart_data !== 8'h31 || grant_id !== 3'd1) begin fails++; $display("FAIL d_byte: got data=%h grant=%0d want 31 1", uart_data, grant_id); end
    drv;
    req_valid = 4'b0100; req_data[23:16] = 8'h42; req_last = 4'b0100;
    for (int k = 1; k <= 15; k++) begin
      smp;
      tests++;
      if (abort !== 1'b0 || busy !== 1'b1 || uart_valid !== 1'b0) begin
        fails++;
        $display("FAIL d_wait%0d: got abort=%b busy=%b valid=%b want 0 1 0", k, abort, busy, uart_valid);
      end
      drv;
    end
    smp;
    tests++; if (abort !== 1'b1 || busy !== 1'b0 || uart_valid !== 1'b0) begin fails++; $display("FAIL d_abort: got abort=%b busy=%b valid=%b want 1 0 0", abort, busy, uart_valid); end
    drv; smp;
    tests++; if (abort !== 1'b0) begin fails++; $display("FAIL d_pulse: got abort=%b want 0", abort); end
    tests++; if (uart_data !== 8'hA2 || grant_id !== 3'd2) begin fails++; $display("FAIL d_next: got data=%h grant=%0d want a2 2", uart_data, grant_id); end
    drv; smp;
    tests++; if (uart_data !== 8'h42) begin fails++; $display("FAIL d_next_dat: got %h want 42", uart_data); end
    drv;
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_reset_mid_packet;
    do_reset;
    req_valid = 4'b0001; req_data = {8'h00, 8'h00, 8'h66, 8'h55}; req_last = 4'b1111; uart_ready = 1'b1;
    drv; drv; drv;
    req_valid = 4'b0010;
    drv; drv;
    uart_ready = 1'b0;
    smp;
    tests++; if (uart_valid !== 1'b1 || uart_data !== 8'h66 || grant_id !== 3'd1) begin fails++; $display("FAIL e_mid: got valid=%b data=%h grant=%0d want 1 66 1", uart_valid, uart_data, grant_id); end
    drv;
    rst = 1'b1; req_valid = 4'b1001;
    drv;
    rst = 1'b0; uart_ready = 1'b1;
    smp;
    tests++; if (uart_valid !== 1'b0 || busy !== 1'b0 || abort !== 1'b0) begin fails++; $display("FAIL e_after: got valid=%b busy=%b abort=%b want 0 0 0", uart_valid, busy, abort); end
    tests++; if (grant_id !== 3'd0 || req_ready !== 4'b0000) begin fails++; $display("FAIL e_after_gr: got grant=%0d ready=%b want 0 0000", grant_id, req_ready); end
    drv; smp;
    tests++; if (uart_data !== 8'hA0 || grant_id !== 3'd0 || abort !== 1'b0) begin fails++; $display("FAIL e_regrant: got data=%h grant=%0d abort=%b want a0 0 0", uart_data, grant_id, abort); end
    drv; drv;
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_no_tag;
    do_reset;
    req_valid = 4'b1000; req_data[31:24] = 8'h01; req_last = 4'b0000; uart_ready = 1'b1;
    smp;
    tests++; if (n_uart_valid !== 1'b0) begin fails++; $display("FAIL f_idle: got valid=%b want 0", n_uart_valid); end
    drv; smp;
    tests++; if (n_uart_valid !== 1'b1 || n_uart_data !== 8'h01 || n_req_ready !== 4'b1000 || n_grant_id !== 3'd3) begin fails++; $display("FAIL f_b0: got valid=%b data=%h ready=%b grant=%0d want 1 01 1000 3", n_uart_valid, n_uart_data, n_req_ready, n_grant_id); end
    drv;
    req_data[31:24] = 8'h02; req_last = 4'b1000; uart_ready = 1'b0;
    smp;
    tests++; if (n_uart_data !== 8'h02 || n_req_ready !== 4'b0000) begin fails++; $display("FAIL f_stall: got data=%h ready=%b want 02 0000", n_uart_data, n_req_ready); end
    drv;
    uart_ready = 1'b1;
    smp;
    tests++; if (n_uart_data !== 8'h02 || n_req_ready !== 4'b1000) begin fails++; $display("FAIL f_b1: got data=%h ready=%b want 02 1000", n_uart_data, n_req_ready); end
    drv;
    req_valid = '0; req_last = '0;
    smp;
    tests++; if (n_busy !== 1'b0 || n_uart_valid !== 1'b0) begin fails++; $display("FAIL f_done: got busy=%b valid=%b want 0 0", n_busy, n_uart_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_ready = 1'b0;
    test_reset;
    test_single_packet;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_reset_mid_packet;
    test_no_tag;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
